bit_stream_serializer: RTL and testbench
========================================

Name: bit_stream_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the serial pattern detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit at a time on out, holding each bit for DIV clocks.
- Selectable bit order; supports gapless back-to-back frames.
- out feeds the detector's serial input; out_valid marks the per-bit sample point.

Parameters:
- WIDTH, 8, word length in bits (≥2)
- DIV, 4, clocks per serial bit (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low (0 = reset, sampled on rising clk edge)
- data_in  input  WIDTH  parallel word to serialize
- msb_first  input  1  bit order, sampled only at accept: 1 = MSB first, 0 = LSB first
- load_valid  input  1  data_in/msb_first valid
- load_ready  output  1  block can accept a word this cycle
- out  output  1  serial bit stream
- out_valid  output  1  one-cycle strobe on the last clock of each bit period
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse on the last clock of the frame's final bit

Behaviour:
- Reset (reset==0 at clk edge), overriding everything including mid-frame:
  - state = IDLE; shift register, bit counter and divider cleared.
  - out=0, out_valid=0, busy=0, frame_done=0, load_ready=1 from the first cycle after the reset edge.
  - Any partial frame is discarded.
- FSM states:
  - IDLE: out=0, busy=0, load_ready=1.
  - SHIFT: busy=1.
- Accept:
  - An accept is load_valid && load_ready at a clk edge.
  - On accept, capture data_in (bit-reversed internally if msb_first==0 so shifting is uniform), set bit_cnt=0, div_cnt=0, and go to SHIFT.
- Timing from an accept at edge T:
  - Bit k is driven on out for cycles T+1+k·DIV through T+(k+1)·DIV.
  - out_valid=1 only in the final cycle of each bit (div_cnt==DIV-1).
  - DIV=1: out_valid is high every cycle of the frame.
  - Last bit (bit_cnt==WIDTH-1, div_cnt==DIV-1): frame_done=1 in the same cycle as its out_valid.
- Gapless streaming:
  - load_ready=1 in IDLE, and also in the frame_done cycle of SHIFT.
  - Accept in the frame_done cycle: load the new word, stay in SHIFT; its first bit appears the next cycle with no idle gap, and busy stays 1.
  - No accept in the frame_done cycle: go to IDLE; out returns to 0 the next cycle.
- load_ready=0 during SHIFT except the frame_done cycle. load_valid then has no effect, and data_in changes do not disturb the frame in flight.
- Counters:
  - div_cnt is ceil(log2(DIV)) bits wide (minimum 1) and wraps DIV-1→0.
  - bit_cnt is ceil(log2(WIDTH)) bits wide and wraps WIDTH-1→0 only at frame end.
- Simultaneous reset and load_valid: reset wins; nothing is captured.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, DIV=4, data_in=8'hB4, msb_first=1, accept at edge T:
  - out = 1,0,1,1,0,1,0,0, each bit held 4 cycles.
  - out_valid at T+4, T+8, … T+32; frame_done only at T+32.
  - Next cycle: IDLE, out=0, load_ready=1.
- Same DIV, data_in=8'h2D, msb_first=0:
  - out = 1,0,1,1,0,1,0,0.
  - A downstream detector fed from out and gated by out_valid sees 101101 within the frame.
- Gapless: first frame 8'hB4, then 8'h2D held with load_valid=1:
  - Second word is accepted exactly at the frame_done cycle (T+32).
  - Its first bit appears at T+33; busy stays 1 throughout.
  - Exactly 16 out_valid strobes and 2 frame_done pulses.
- Busy rejection:
  - Pulse load_valid with 8'hFF at T+10 during frame 8'hB4.
  - load_ready=0, so the word is ignored and the output bit sequence is unchanged.
- Reset mid-frame:
  - Drive reset=0 at T+13 during frame 8'hB4.
  - Next cycle: out=0, busy=0, out_valid=0, load_ready=1, no frame_done.
  - A new load after reset=1 produces a clean full frame.
- DIV=1, WIDTH=8, 8'hA5, msb_first=1:
  - out = 1,0,1,0,0,1,0,1 on consecutive cycles T+1..T+8.
  - out_valid high for all 8 cycles; frame_done at T+8.

Source files
------------

// File: rtl/bit_stream_serializer.sv
`default_nettype none
// ============================================================================
// bit_stream_serializer: valid/ready parallel-in, serial-out with DIV clocks/bit
// Revision: 1.0
// ============================================================================
module bit_stream_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_first,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [WIDTH-1:0] load_word;
  logic             bit_end;
  logic             accept;

  // LSB-first words are reversed on capture so the shifter always emits bit WIDTH-1
  always_comb begin
    load_word = data_in;
    if (!msb_first) begin
      for (int i = 0; i < WIDTH; i++) begin
        load_word[i] = data_in[WIDTH-1-i];
      end
    end
  end

  assign busy       = (state_q == SHIFT);
  assign bit_end    = busy && (div_cnt_q == DIV_LAST);
  assign out_valid  = bit_end;
  assign frame_done = bit_end && (bit_cnt_q == BIT_LAST);
  assign load_ready = (state_q == IDLE) || frame_done;
  assign out        = busy && shift_q[WIDTH-1];
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    if (accept) begin
      state_d   = SHIFT;
      shift_d   = load_word;
      bit_cnt_d = '0;
      div_cnt_d = '0;
    end else if (state_q == SHIFT) begin
      if (frame_done) begin
        state_d   = IDLE;
        shift_d   = '0;
        bit_cnt_d = '0;
        div_cnt_d = '0;
      end else if (bit_end) begin
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_stream_serializer.sv
`default_nettype none
// ============================================================================
// tb_bit_stream_serializer: self-checking bench for bit_stream_serializer
// Revision: 1.0
// ============================================================================
module tb_bit_stream_serializer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int FL = W * D;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         msb_first = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready, out, out_valid, busy, frame_done;
  logic [W-1:0] data_in1 = '0;
  logic         msb_first1 = 1'b0;
  logic         load_valid1 = 1'b0;
  logic         load_ready1, out1, out_valid1, busy1, frame_done1;
  logic [4:0]   st, st1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bit_stream_serializer #(.WIDTH(W), .DIV(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .msb_first  (msb_first),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  bit_stream_serializer #(.WIDTH(W), .DIV(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in1),
    .msb_first  (msb_first1),
    .load_valid (load_valid1),
    .load_ready (load_ready1),
    .out        (out1),
    .out_valid  (out_valid1),
    .busy       (busy1),
    .frame_done (frame_done1)
  );

  // Status order: {out, out_valid, frame_done, busy, load_ready}
  assign st  = {out, out_valid, frame_done, busy, load_ready};
  assign st1 = {out1, out_valid1, frame_done1, busy1, load_ready1};

  // k-th transmitted bit of a word in the requested order
  function automatic logic exp_bit(input logic [W-1:0] w, input logic msb, input int k);
    return msb ? w[W-1-k] : w[k];
  endfunction

  task automatic test_reset();
    reset = 1'b0; load_valid = 1'b1; data_in = 8'hFF; msb_first = 1'b1;
    load_valid1 = 1'b1; data_in1 = 8'hFF; msb_first1 = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (st !== 5'b00001) begin
      miscompares++; $display("FAIL reset_hold: got %b exp %b", st, 5'b00001);
    end
    vectors++;
    if (st1 !== 5'b00001) begin
      miscompares++; $display("FAIL reset_hold_div1: got %b exp %b", st1, 5'b00001);
    end
    reset = 1'b1; load_valid = 1'b0; load_valid1 = 1'b0;
    @(negedge clk);
    vectors++;
    if (st !== 5'b00001) begin
      miscompares++; $display("FAIL reset_release: got %b exp %b", st, 5'b00001);
    end
  endtask

  task automatic test_single_frame(input logic [W-1:0] word, input logic msb,
                                   output logic [W-1:0] seen);
    logic [4:0] exp;
    seen = '0;
    @(negedge clk);
    data_in = word; msb_first = msb; load_valid = 1'b1;
    for (int c = 1; c <= FL; c++) begin
      @(negedge clk);
      exp = {exp_bit(word, msb, (c-1)/D), (c % D) == 0, c == FL, 1'b1, c == FL};
      vectors++;
      if (st !== exp) begin
        miscompares++; $display("FAIL frame %h c=%0d: got %b exp %b", word, c, st, exp);
      end
      if (out_valid) seen = {seen[W-2:0], out};
      load_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (st !== 5'b00001) begin
      miscompares++; $display("FAIL frame_idle: got %b exp %b", st, 5'b00001);
    end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] seen;
    test_single_frame(8'hB4, 1'b1, seen);
    vectors++;
    if (seen !== 8'hB4) begin
      miscompares++; $display("FAIL msb_first_seq: got %h exp %h", seen, 8'hB4);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] seen;
    logic         found;
    test_single_frame(8'h2D, 1'b0, seen);
    found = 1'b0;
    for (int i = 0; i <= W - 6; i++) begin
      if (seen[W-1-i -: 6] == 6'b101101) found = 1'b1;
    end
    vectors++;
    if (found !== 1'b1) begin
      miscompares++; $display("FAIL lsb_detect: got seq %b, pattern 101101 absent", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]   exp;
    logic [W-1:0] word;
    logic         msb;
    int           cc, strobes, dones;
    strobes = 0; dones = 0;
    @(negedge clk);
    data_in = 8'hB4; msb_first = 1'b1; load_valid = 1'b1;
    for (int c = 1; c <= 2*FL; c++) begin
      @(negedge clk);
      cc   = (c - 1) % FL + 1;
      word = (c <= FL) ? 8'hB4 : 8'h2D;
      msb  = (c <= FL);
      exp  = {exp_bit(word, msb, (cc-1)/D), (cc % D) == 0, cc == FL, 1'b1, cc == FL};
      vectors++;
      if (st !== exp) begin
        miscompares++; $display("FAIL b2b c=%0d: got %b exp %b", c, st, exp);
      end
      strobes += int'(out_valid);
      dones   += int'(frame_done);
      if (c == 1) begin data_in = 8'h2D; msb_first = 1'b0; end
      if (c == FL + 1) load_valid = 1'b0;
    end
    vectors++;
    if (strobes != 2*W || dones != 2) begin
      miscompares++;
      $display("FAIL b2b_counts: got strobes=%0d dones=%0d exp %0d/2", strobes, dones, 2*W);
    end
    @(negedge clk);
    vectors++;
    if (st !== 5'b00001) begin
      miscompares++; $display("FAIL b2b_idle: got %b exp %b", st, 5'b00001);
    end
  endtask

  task automatic test_busy_reject();
    logic [4:0] exp;
    @(negedge clk);
    data_in = 8'hB4; msb_first = 1'b1; load_valid = 1'b1;
    for (int c = 1; c <= FL; c++) begin
      @(negedge clk);
      exp = {exp_bit(8'hB4, 1'b1, (c-1)/D), (c % D) == 0, c == FL, 1'b1, c == FL};
      vectors++;
      if (st !== exp) begin
        miscompares++; $display("FAIL busy_reject c=%0d: got %b exp %b", c, st, exp);
      end
      if (c == 10) begin load_valid = 1'b1; data_in = 8'hFF; end
      else load_valid = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (st !== 5'b00001) begin
      miscompares++; $display("FAIL busy_reject_idle: got %b exp %b", st, 5'b00001);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0]   exp;
    logic [W-1:0] seen, word;
    @(negedge clk);
    data_in = 8'hB4; msb_first = 1'b1; load_valid = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      exp = {exp_bit(8'hB4, 1'b1, (c-1)/D), (c % D) == 0, 1'b0, 1'b1, 1'b0};
      vectors++;
      if (st !== exp) begin
        miscompares++; $display("FAIL reset_mid_pre c=%0d: got %b exp %b", c, st, exp);
      end
      load_valid = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (st !== 5'b00001) begin
      miscompares++; $display("FAIL reset_mid: got %b exp %b", st, 5'b00001);
    end
    reset = 1'b1;
    word = W'($urandom);
    test_single_frame(word, 1'b1, seen);
    vectors++;
    if (seen !== word) begin
      miscompares++; $display("FAIL reset_mid_reload: got %h exp %h", seen, word);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] word, nword;
    logic         msb, nmsb;
    logic [4:0]   exp;
    int           gap;
    word = W'($urandom); msb = 1'($urandom);
    @(negedge clk);
    data_in = word; msb_first = msb; load_valid = 1'b1;
    for (int f = 0; f < 24; f++) begin
      gap   = $urandom_range(0, 2);
      nword = W'($urandom); nmsb = 1'($urandom);
      for (int c = 1; c <= FL; c++) begin
        @(negedge clk);
        exp = {exp_bit(word, msb, (c-1)/D), (c % D) == 0, c == FL, 1'b1, c == FL};
        vectors++;
        if (st !== exp) begin
          miscompares++; $display("FAIL random f=%0d c=%0d: got %b exp %b", f, c, st, exp);
        end
        if (c < FL) begin
          load_valid = 1'($urandom); data_in = W'($urandom); msb_first = 1'($urandom);
        end else if (gap == 0 && f < 23) begin
          load_valid = 1'b1; data_in = nword; msb_first = nmsb;
        end else begin
          load_valid = 1'b0;
        end
      end
      if (gap != 0 || f == 23) begin
        for (int g = 1; g <= ((gap == 0) ? 1 : gap); g++) begin
          @(negedge clk);
          vectors++;
          if (st !== 5'b00001) begin
            miscompares++; $display("FAIL random_idle f=%0d: got %b exp %b", f, st, 5'b00001);
          end
          if (g == gap && f < 23) begin
            load_valid = 1'b1; data_in = nword; msb_first = nmsb;
          end else begin
            load_valid = 1'b0;
          end
        end
      end
      word = nword; msb = nmsb;
    end
  endtask

  task automatic test_div1();
    logic [W-1:0] word, nword;
    logic         msb, nmsb;
    logic [4:0]   exp;
    word = 8'hA5; msb = 1'b1;
    @(negedge clk);
    data_in1 = word; msb_first1 = msb; load_valid1 = 1'b1;
    for (int f = 0; f < 6; f++) begin
      nword = W'($urandom); nmsb = 1'($urandom);
      for (int c = 1; c <= W; c++) begin
        @(negedge clk);
        exp = {exp_bit(word, msb, c-1), 1'b1, c == W, 1'b1, c == W};
        vectors++;
        if (st1 !== exp) begin
          miscompares++; $display("FAIL div1 f=%0d c=%0d: got %b exp %b", f, c, st1, exp);
        end
        if (c == W && f < 5) begin
          load_valid1 = 1'b1; data_in1 = nword; msb_first1 = nmsb;
        end else begin
          load_valid1 = 1'b0;
        end
      end
      word = nword; msb = nmsb;
    end
    @(negedge clk);
    vectors++;
    if (st1 !== 5'b00001) begin
      miscompares++; $display("FAIL div1_idle: got %b exp %b", st1, 5'b00001);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid();
    test_random();
    test_div1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
